delivery_game_scroller: RTL and testbench
=========================================

# delivery_game_scroller

Timing datapath driven by `delivery_game_uc`. It converts the UC's `count_map` and `get_velocity` commands into map-scroll steps at a velocity-dependent period, and tracks player lives. It produces `velocity_ready` and `game_over`, the two status inputs the UC uses to leave `PLAYING`.

## Interface
Parameters:
- `BASE_PERIOD`, default 1000: clock cycles per scroll step at velocity 0. Must be ≤ 65535.
- `PERIOD_DEC`, default 100: cycles removed from the period per velocity unit.
- `MIN_PERIOD`, default 200: lower clamp on the period. Must be ≥ 2.
- `VEL_MAX`, default 7: velocity saturation value. Must be ≤ 7.
- `STEPS_PER_LEVEL`, default 16: scroll steps between `velocity_ready` requests.
- `POS_W`, default 6: width of the map position counter.
- `LIVES`, default 3: starting lives. Must be ≤ 3.

Ports (clock and reset first):
- `clock`, in, 1: single clock; all state is updated on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `clear`, in, 1: synchronous clear, driven by UC `reset_out`.
- `count_map`, in, 1: scroll enable, driven by UC `count_map`.
- `get_velocity`, in, 1: velocity increment strobe, driven by UC `get_velocity`.
- `hit`, in, 1: obstacle collision flag, sampled only on terminal count.
- `velocity`, out, 3: current velocity.
- `map_pos`, out, POS_W: map scroll position.
- `step`, out, 1: one-cycle pulse per scroll step.
- `velocity_ready`, out, 1: one-cycle level-up request to the UC.
- `lives`, out, 2: remaining lives.
- `game_over`, out, 1: level output; high once lives reach 0.

## Operation
- Internal FSM has three states: IDLE, RUN, OVER.
  - IDLE → RUN when `count_map`=1.
  - RUN → OVER when a hit is taken while `lives`=1.
  - Every state → IDLE on `clear`.
- Priority per edge, highest first: `reset_n` low, `clear`, then normal operation.
- Reset and clear values:
  - `velocity`=0, `map_pos`=0, `step`=0, `velocity_ready`=0, `game_over`=0.
  - `lives`=LIVES; period counter `cnt`=0; level step counter `lvl`=0; state IDLE.
- Velocity update: on each cycle with `get_velocity`=1, `velocity` ← min(`velocity`+1, VEL_MAX), and `lvl` ← 0. Each cycle the strobe is high counts as one increment. This is valid in any state except OVER.
- Period: `period` = BASE_PERIOD − `velocity`·PERIOD_DEC.
  - Compute in at least 20 bits.
  - If `velocity`·PERIOD_DEC > BASE_PERIOD − MIN_PERIOD, `period` = MIN_PERIOD (clamp, no underflow).
- Counting happens only in RUN with `count_map`=1. Terminal count is `cnt` ≥ `period`−1. Using ≥ makes a mid-count velocity increase end the step on the next enabled cycle.
- On terminal count:
  - `cnt` ← 0.
  - `map_pos` ← `map_pos`+1, wrapping modulo 2^POS_W.
  - `step` ← 1.
  - `lvl` ← `lvl`+1.
- Hit handling on terminal count: if `hit`=1, `lives` ← `lives`−1. If `lives` was 1, `game_over` ← 1 and state ← OVER.
- Level-up on terminal count: if `lvl`+1 = STEPS_PER_LEVEL and `velocity` < VEL_MAX, then `velocity_ready` ← 1 and `lvl` ← 0. At VEL_MAX `lvl` saturates and no request is issued.
- When the final life is lost on a step that completes a level, `game_over` wins and `velocity_ready` stays 0.
- With `count_map`=0 in RUN, `cnt`, `map_pos` and `lvl` hold their values.
- In OVER, all counters are frozen and `get_velocity` and `hit` are ignored. `game_over` stays 1 until `clear` or reset.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `step` and `velocity_ready` are high for exactly the one cycle after the terminal-count edge.
- `velocity` changes on the edge where `get_velocity` is sampled. The new period applies from the next cycle.
- From an enabled RUN with `cnt`=0, the first `step` appears `period` cycles later. Steps then repeat every `period` enabled cycles.
- `lives` and `game_over` update on the same edge that raises `step`.
- UC handshake:
  - `velocity_ready` enters the UC in `PLAYING`, and the UC answers with one `get_velocity` cycle one clock later.
  - The scroller continues counting during that exchange; `count_map` stays high in `GET_VELOCITY`.
- Asynchronous reset mid-step forces the reset values immediately. Counting resumes only via IDLE → RUN.

## Test plan
Bench parameters: BASE_PERIOD=10, PERIOD_DEC=2, MIN_PERIOD=4, STEPS_PER_LEVEL=4, POS_W=6, LIVES=3.
- Pulse `reset_n` low mid-simulation → all outputs take their reset values asynchronously; `lives`=3.
- One `get_velocity` cycle, then hold `count_map`=1 → `velocity`=1, `step` every 8 cycles, `map_pos` 0→1→2→3→4. `velocity_ready` pulses in the same cycle as the 4th `step` pulse.
- Eight `get_velocity` cycles → `velocity` saturates at 7 and `period` clamps to 4 (`step` every 4 cycles). `velocity_ready` never asserts after 16 steps.
- Hold `hit`=1 while scrolling → `lives` goes 3→2→1→0 on three consecutive steps and `game_over`=1 with the third. After that, `map_pos` is frozen and `step`=0. `clear` returns `lives`=3 and `game_over`=0.
- Drop `count_map` for 5 cycles at `cnt`=3 with `period`=8 → `step` is delayed by exactly 5 cycles. Separately, raise `velocity` from 1 to 4 (clamped `period`=4) at `cnt`=6 → `step` on the next enabled cycle.
- Run 64 steps → `map_pos` wraps 63→0. Final-life hit coincident with the 4th level step → `game_over`=1 and `velocity_ready`=0.

Source files
------------

// File: rtl/delivery_game_scroller.sv
// delivery_game_scroller: map-scroll timer and life tracker for delivery_game_uc.
// Ports: clock/reset_n; clear, count_map, get_velocity, hit in;
//        velocity, map_pos, step, velocity_ready, lives, game_over out.
module delivery_game_scroller #(
    parameter int unsigned BASE_PERIOD     = 1000,
    parameter int unsigned PERIOD_DEC      = 100,
    parameter int unsigned MIN_PERIOD      = 200,
    parameter int unsigned VEL_MAX         = 7,
    parameter int unsigned STEPS_PER_LEVEL = 16,
    parameter int unsigned POS_W           = 6,
    parameter int unsigned LIVES           = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             count_map,
    input  logic             get_velocity,
    input  logic             hit,
    output logic [2:0]       velocity,
    output logic [POS_W-1:0] map_pos,
    output logic             step,
    output logic             velocity_ready,
    output logic [1:0]       lives,
    output logic             game_over
);
    localparam int unsigned LVL_W = $clog2(STEPS_PER_LEVEL + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [2:0]       vel_q, vel_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [1:0]       lives_q, lives_d;
    logic             step_q, step_d;
    logic             vrdy_q, vrdy_d;
    logic             over_q, over_d;

    logic [19:0]      dec;
    logic [19:0]      period;
    logic             run_en;
    logic             vel_en;
    logic             term;
    logic             last_hit;

    // Period shrinks with velocity; clamp before the subtraction can underflow.
    always_comb begin
        dec = 20'(vel_q) * 20'(PERIOD_DEC);
        if (dec > 20'(BASE_PERIOD - MIN_PERIOD)) begin
            period = 20'(MIN_PERIOD);
        end else begin
            period = 20'(BASE_PERIOD) - dec;
        end
    end

    // >= so a mid-step velocity increase ends the step on the next enabled cycle.
    assign term     = run_en && ({4'd0, cnt_q} >= (period - 20'd1));
    assign last_hit = term && hit && (lives_q == 2'd1);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (count_map) state_d = RUN;
                RUN:     if (last_hit) state_d = OVER;
                OVER:    state_d = OVER;
                default: state_d = IDLE;
            endcase
        end
    end

    // State decode
    always_comb begin
        run_en = (state_q == RUN) && count_map;
        vel_en = (state_q != OVER);
    end

    // Datapath next-state
    always_comb begin
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        vel_d   = vel_q;
        pos_d   = pos_q;
        lives_d = lives_q;
        over_d  = over_q;
        step_d  = 1'b0;
        vrdy_d  = 1'b0;
        if (run_en) begin
            if (term) begin
                cnt_d  = 16'd0;
                pos_d  = pos_q + 1'b1;
                step_d = 1'b1;
                if (hit && (lives_q != 2'd0)) begin
                    lives_d = lives_q - 2'd1;
                end
                if (last_hit) begin
                    over_d = 1'b1;
                end else if (lvl_q == LVL_W'(STEPS_PER_LEVEL - 1)) begin
                    // At top speed the level counter parks here.
                    if (vel_q < 3'(VEL_MAX)) begin
                        vrdy_d = 1'b1;
                        lvl_d  = '0;
                    end
                end else begin
                    lvl_d = lvl_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        if (vel_en && get_velocity) begin
            lvl_d = '0;
            if (vel_q < 3'(VEL_MAX)) begin
                vel_d = vel_q + 3'd1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            lvl_q   <= '0;
            vel_q   <= '0;
            pos_q   <= '0;
            lives_q <= 2'(LIVES);
            step_q  <= 1'b0;
            vrdy_q  <= 1'b0;
            over_q  <= 1'b0;
        end else if (clear) begin
            cnt_q   <= '0;
            lvl_q   <= '0;
            vel_q   <= '0;
            pos_q   <= '0;
            lives_q <= 2'(LIVES);
            step_q  <= 1'b0;
            vrdy_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            vel_q   <= vel_d;
            pos_q   <= pos_d;
            lives_q <= lives_d;
            step_q  <= step_d;
            vrdy_q  <= vrdy_d;
            over_q  <= over_d;
        end
    end

    assign velocity       = vel_q;
    assign map_pos        = pos_q;
    assign step           = step_q;
    assign velocity_ready = vrdy_q;
    assign lives          = lives_q;
    assign game_over      = over_q;

endmodule

// File: tb/tb_delivery_game_scroller.sv
// tb_delivery_game_scroller: scoreboard bench for delivery_game_scroller.
// Model predicts step events; a monitor pops and compares them.
module tb_delivery_game_scroller;
    localparam int BASE = 10;
    localparam int DEC  = 2;
    localparam int MINP = 4;
    localparam int VMAX = 7;
    localparam int SPL  = 4;
    localparam int PW   = 6;
    localparam int NL   = 3;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          count_map = 1'b0;
    logic          get_velocity = 1'b0;
    logic          hit = 1'b0;
    logic [2:0]    velocity;
    logic [PW-1:0] map_pos;
    logic          step;
    logic          velocity_ready;
    logic [1:0]    lives;
    logic          game_over;

    delivery_game_scroller #(
        .BASE_PERIOD(BASE), .PERIOD_DEC(DEC), .MIN_PERIOD(MINP),
        .VEL_MAX(VMAX), .STEPS_PER_LEVEL(SPL), .POS_W(PW), .LIVES(NL)
    ) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .count_map(count_map), .get_velocity(get_velocity), .hit(hit),
        .velocity(velocity), .map_pos(map_pos), .step(step),
        .velocity_ready(velocity_ready), .lives(lives), .game_over(game_over)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        int pos;
        int lv;
        int vel;
        bit over;
        bit vr;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  cyc = 0;
    int  n_chk = 0;
    int  n_pass = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: game rules in plain integer arithmetic.
    int m_vel, m_cnt, m_pos, m_lvl, m_lives;
    bit m_run, m_over;

    function automatic int period_of(int v);
        int p;
        p = BASE - v * DEC;
        return (p < MINP) ? MINP : p;
    endfunction

    task automatic model_reset();
        m_vel = 0; m_cnt = 0; m_pos = 0; m_lvl = 0;
        m_lives = NL; m_run = 0; m_over = 0;
    endtask

    task automatic model_edge(bit cm, bit gv, bit h, bit clr);
        ev_t e;
        bit  was_over;
        bit  fired;
        if (clr) begin
            model_reset();
            return;
        end
        was_over = m_over;
        fired = 0;
        e.vr = 0;
        if (m_run && !was_over && cm) begin
            m_cnt++;
            if (m_cnt >= period_of(m_vel)) begin
                fired = 1;
                m_cnt = 0;
                m_pos = (m_pos + 1) % (1 << PW);
                m_lvl++;
                if (h) begin
                    m_lives--;
                    if (m_lives == 0) m_over = 1;
                end
                if (!m_over && m_lvl >= SPL && m_vel < VMAX) begin
                    e.vr = 1;
                    m_lvl = 0;
                end
            end
        end
        if (!m_run && cm) m_run = 1;
        if (!was_over && gv) begin
            if (m_vel < VMAX) m_vel++;
            m_lvl = 0;
        end
        if (fired) begin
            e.cyc = cyc + 1;
            e.pos = m_pos;
            e.lv = m_lives;
            e.vel = m_vel;
            e.over = m_over;
            q.push_back(e);
        end
    endtask

    task automatic tick(bit cm, bit gv = 0, bit h = 0, bit clr = 0);
        count_map = cm;
        get_velocity = gv;
        hit = h;
        clear = clr;
        model_edge(cm, gv, h, clr);
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
        check("queue_drained", q.size(), 0);
    endtask

    task automatic check_reset_vals();
        check("rst_velocity", velocity, 0);
        check("rst_map_pos", map_pos, 0);
        check("rst_step", step, 0);
        check("rst_vready", velocity_ready, 0);
        check("rst_lives", lives, NL);
        check("rst_game_over", game_over, 0);
    endtask

    // Monitor
    always @(negedge clock) begin
        if (reset_n && (step || velocity_ready)) begin
            if (q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                mon_e = q.pop_front();
                check("step", step, 1);
                check("step_cycle", cyc, mon_e.cyc);
                check("vready", velocity_ready, mon_e.vr);
                check("map_pos", map_pos, mon_e.pos);
                check("lives", lives, mon_e.lv);
                check("game_over", game_over, mon_e.over);
                check("velocity", velocity, mon_e.vel);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_vals();
        reset_n = 1'b1;

        // One increment, then scroll at period 8
        tick(0, 1);
        check("vel_after_one", velocity, m_vel);
        repeat (40) tick(1);
        settle();

        // Saturate velocity, clamped period, no level requests
        tick(0, 0, 0, 1);
        repeat (8) tick(0, 1);
        check("vel_saturated", velocity, m_vel);
        repeat (70) tick(1);
        settle();

        // Continuous hits to game over, then frozen
        tick(0, 0, 0, 1);
        repeat (45) tick(1, 0, 1);
        settle();
        check("over_level", game_over, 1);
        check("over_lives", lives, 0);
        check("over_pos_frozen", map_pos, m_pos);
        tick(0, 0, 0, 1);
        check("clear_lives", lives, NL);
        check("clear_game_over", game_over, 0);

        // Pause count_map mid-step, then raise speed mid-step
        tick(0, 1);
        tick(1);
        repeat (3) tick(1);
        repeat (5) tick(0);
        repeat (10) tick(1);
        tick(1);
        repeat (3) tick(0, 1);
        tick(1);
        settle();
        check("fast_step", step, 1);

        // Wrap map_pos past 63
        tick(0, 0, 0, 1);
        repeat (8) tick(0, 1);
        repeat (300) tick(1);
        settle();
        check("wrap_pos", map_pos, m_pos);

        // Final life lost on the level-completing step
        tick(0, 0, 0, 1);
        repeat (11) tick(1);
        repeat (40) tick(1, 0, 1);
        settle();
        check("final_over", game_over, 1);
        check("final_vready", velocity_ready, 0);
        tick(0, 0, 0, 1);

        // Random traffic with an asynchronous reset in the middle
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                settle();
                reset_n = 1'b0;
                #1;
                check_reset_vals();
                reset_n = 1'b1;
                model_reset();
            end
            tick($urandom_range(0, 9) != 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 299) == 0);
        end
        settle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
